// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares an HD44780-style 8-bit LCD write bus between two
// valid/ready requesters. It enforces the power-up wait and the rs/data setup,
// enable pulse, hold and instruction execution times. A per-packet lock keeps
// multi-byte fields from interleaving.
module lcd_bus_arbiter #(
  parameter int POWERUP_CYC    = 2_500_000,
  parameter int SETUP_CYC      = 4,
  parameter int EN_HIGH_CYC    = 24,
  parameter int HOLD_CYC       = 4,
  parameter int EXEC_CYC       = 2000,
  parameter int CLEAR_EXEC_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       owner
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(POWERUP_CYC, SETUP_CYC), max2(EN_HIGH_CYC, HOLD_CYC)),
                                max2(EXEC_CYC, CLEAR_EXEC_CYC));
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  // Counter reload values: the counter runs from N-1 down to 0, giving N cycles per state.
  localparam logic [CNT_W-1:0] LD_PU    = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(CLEAR_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_EXEC    = 3'd5
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             lock, rr;
  logic             gnt0, gnt1, accept, cnt_done, exec_long;

  // Grant selection: a locked bus belongs to its owner, otherwise a lone
  // requester wins and a tie goes to the round-robin pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock) begin
      gnt0 = req0_valid && (owner == 1'b0);
      gnt1 = req1_valid && (owner == 1'b1);
    end else begin
      gnt0 = req0_valid && (!req1_valid || (rr == 1'b0));
      gnt1 = req1_valid && (!req0_valid || (rr == 1'b1));
    end
  end

  assign req0_ready = (state == ST_IDLE) && gnt0;
  assign req1_ready = (state == ST_IDLE) && gnt1;
  assign accept     = req0_ready || req1_ready;
  assign cnt_done   = (cnt == CNT_ZERO);
  // Clear and return-home need the long execution time.
  assign exec_long  = !lcd_rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02) || (lcd_data == 8'h03));

  assign lcd_rw = 1'b0;
  assign lcd_en = (state == ST_PULSE);
  assign busy   = (state != ST_IDLE);

  // State and timing counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_POWERUP;
      cnt   <= LD_PU;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic: each timed state counts down, then reloads the counter for the next state.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_POWERUP: begin
        if (cnt_done) begin
          next_state = ST_IDLE;
          next_cnt   = CNT_ZERO;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          next_state = ST_SETUP;
          next_cnt   = LD_SETUP;
        end else begin
          next_cnt = CNT_ZERO;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          next_state = ST_PULSE;
          next_cnt   = LD_EN;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_done) begin
          next_state = ST_HOLD;
          next_cnt   = LD_HOLD;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          next_state = ST_EXEC;
          next_cnt   = exec_long ? LD_CLEAR : LD_EXEC;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      ST_EXEC: begin
        if (cnt_done) begin
          next_state = ST_IDLE;
          next_cnt   = CNT_ZERO;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      default: begin
        next_state = ST_POWERUP;
        next_cnt   = LD_PU;
      end
    endcase
  end

  // Accepted byte, ownership, packet lock and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      owner    <= 1'b0;
      lock     <= 1'b0;
      rr       <= 1'b0;
    end else if (accept) begin
      lcd_rs   <= gnt1 ? req1_rs : req0_rs;
      lcd_data <= gnt1 ? req1_data : req0_data;
      owner    <= gnt1;
      lock     <= gnt1 ? !req1_last : !req0_last;
      if (gnt1 ? req1_last : req0_last) begin
        rr <= !gnt1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter. A transaction-level model predicts
// grants, enable windows and busy periods from absolute cycle numbers.
module tb_lcd_bus_arbiter;
  localparam int P_PU = 10, P_S = 2, P_E = 3, P_H = 2, P_X = 5, P_C = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req0_valid, req0_rs, req0_last, req0_ready;
  logic       req1_valid, req1_rs, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data, lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, busy, owner;

  lcd_bus_arbiter #(
    .POWERUP_CYC(P_PU), .SETUP_CYC(P_S), .EN_HIGH_CYC(P_E),
    .HOLD_CYC(P_H), .EXEC_CYC(P_X), .CLEAR_EXEC_CYC(P_C)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
    .busy(busy), .owner(owner)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: cycle index since reset release, first cycle the bus is free,
  // enable window of the last accepted byte, lock/owner/rr and the latched byte.
  int         cyc, free_at, en_lo, en_hi;
  logic       m_lock, m_owner, m_rr, m_rs;
  logic [7:0] m_data;

  // Requester byte queues: {rs, last, data}, and percent chance of offering.
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int         pct0, pct1;

  task automatic model_reset();
    cyc = 0; free_at = P_PU; en_lo = 1; en_hi = 0;
    m_lock = 1'b0; m_owner = 1'b0; m_rr = 1'b0; m_rs = 1'b0; m_data = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive();
    if (q0.size() > 0 && $urandom_range(99) < pct0) begin
      req0_valid = 1'b1; {req0_rs, req0_last, req0_data} = q0[0];
    end else begin
      req0_valid = 1'b0; {req0_rs, req0_last, req0_data} = 10'($urandom);
    end
    if (q1.size() > 0 && $urandom_range(99) < pct1) begin
      req1_valid = 1'b1; {req1_rs, req1_last, req1_data} = q1[0];
    end else begin
      req1_valid = 1'b0; {req1_rs, req1_last, req1_data} = 10'($urandom);
    end
  endtask

  // One cycle: compare outputs against the model, commit any accept, advance.
  task automatic step(output logic acc0, output logic acc1);
    logic idle, g0, g1, n, lst;
    #1;
    idle = (cyc >= free_at);
    if (m_lock) begin
      g0 = idle && req0_valid && !m_owner;
      g1 = idle && req1_valid && m_owner;
    end else begin
      g0 = idle && req0_valid && (!req1_valid || !m_rr);
      g1 = idle && req1_valid && (!req0_valid || m_rr);
    end
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("lcd_en", lcd_en, (cyc >= en_lo && cyc <= en_hi));
    chk("busy", busy, !idle);
    chk("owner", owner, m_owner);
    chk("lcd_rs", lcd_rs, m_rs);
    chk("lcd_data", lcd_data, m_data);
    chk("lcd_rw", lcd_rw, 1'b0);
    if (g0 || g1) begin
      n       = g1;
      m_rs    = n ? req1_rs : req0_rs;
      m_data  = n ? req1_data : req0_data;
      lst     = n ? req1_last : req0_last;
      m_owner = n;
      m_lock  = !lst;
      if (lst) m_rr = !n;
      en_lo   = cyc + 1 + P_S;
      en_hi   = cyc + P_S + P_E;
      free_at = cyc + 1 + P_S + P_E + P_H +
                ((!m_rs && m_data >= 8'h01 && m_data <= 8'h03) ? P_C : P_X);
    end
    acc0 = g0;
    acc1 = g1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_one();
    logic a0, a1;
    drive();
    step(a0, a1);
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < max_cyc) begin
      run_one();
      n++;
    end
    vectors++;
    assert (q0.size() == 0 && q1.size() == 0) else begin
      miscompares++;
      $error("FAIL drain_timeout: %0d/%0d bytes left, expected 0", q0.size(), q1.size());
    end
    repeat (3) run_one();
  endtask

  task automatic reset_phase(input int n);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_en", lcd_en, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_data", lcd_data, 8'h00);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] d;
    logic       r;
    int         guard;
    reset = 1'b0;
    pct0 = 100; pct1 = 100;
    model_reset();

    // Power-up wait with req0 held valid, then two data bytes back to back.
    q0.push_back({1'b1, 1'b1, 8'h41});
    q0.push_back({1'b1, 1'b1, 8'h42});
    drive();
    reset_phase(2);
    drain(200);

    // Clear/home commands use the long execution time; rs=1 data 0x01 does not.
    q1.push_back({1'b0, 1'b1, 8'h01});
    q1.push_back({1'b1, 1'b1, 8'h01});
    q1.push_back({1'b0, 1'b1, 8'h02});
    q1.push_back({1'b0, 1'b1, 8'h03});
    q1.push_back({1'b0, 1'b1, 8'h04});
    drain(300);

    // Both requesters continuously valid with single-byte packets: alternation.
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'b1, 1'b1, 8'h30 + 8'(i)});
      q1.push_back({1'b1, 1'b1, 8'h60 + 8'(i)});
    end
    drain(300);

    // Locked 3-byte packet from req0 while req1 waits.
    q0.push_back({1'b0, 1'b0, 8'h86});
    q0.push_back({1'b1, 1'b0, 8'h32});
    q0.push_back({1'b1, 1'b1, 8'h35});
    q1.push_back({1'b1, 1'b1, 8'h58});
    q1.push_back({1'b1, 1'b1, 8'h59});
    drain(300);

    // Randomized packets with intermittent valid.
    pct0 = 60; pct1 = 60;
    for (int p = 0; p < 40; p++) begin
      int len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(3) == 0) begin
          r = 1'b0; d = 8'($urandom_range(1, 3));
        end else begin
          r = 1'($urandom); d = 8'($urandom);
        end
        if (p % 2 == 0) q0.push_back({r, (b == len - 1), d});
        else            q1.push_back({r, (b == len - 1), d});
      end
    end
    drain(10000);

    // Reset during the enable pulse discards the byte and restarts power-up.
    pct0 = 100; pct1 = 100;
    q0.push_back({1'b1, 1'b1, 8'h7A});
    guard = 0;
    while (!(cyc >= en_lo && cyc <= en_hi) && guard < 100) begin
      run_one();
      guard++;
    end
    q0.delete();
    q1.delete();
    drive();
    #1;
    chk("en_before_reset", lcd_en, 1'b1);
    reset_phase(1);
    q0.push_back({1'b1, 1'b1, 8'h55});
    q1.push_back({1'b1, 1'b1, 8'h66});
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Shares the HD44780-style LCD1602 8-bit write bus between two independent requesters. Typical requesters are the static-text/init sequencer and the live sensor-field updater. Each requester offers single bytes over a valid/ready handshake, and a byte is tagged as either command or data. The block enforces the power-up wait, the rs/data setup time, the enable pulse width, the hold time, and the per-instruction execution time, so requesters never deal with LCD timing. Requesters can lock the bus across a multi-byte packet (cursor-set plus digits), so fields from the two requesters never interleave.

## Interface
- POWERUP_CYC, 2_500_000: idle cycles after reset before the first transfer (50 ms at 50 MHz).
- SETUP_CYC, 4: cycles rs/data are stable before lcd_en rises. Must be ≥1.
- EN_HIGH_CYC, 24: cycles lcd_en is high. Must be ≥1.
- HOLD_CYC, 4: cycles rs/data are held after lcd_en falls. Must be ≥1.
- EXEC_CYC, 2000: wait after hold for ordinary commands and data (40 µs). Must be ≥1.
- CLEAR_EXEC_CYC, 82000: wait after hold for clear (0x01) and home (0x02/0x03) commands (1.64 ms).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- reqN_valid  in  1  requester N (N=0,1) offers a byte.
- reqN_rs  in  1  0 = command, 1 = data.
- reqN_data  in  8  byte to write.
- reqN_last  in  1  this byte ends the packet. The bus lock is released after it.
- reqN_ready  out  1  byte accepted this cycle when high with reqN_valid.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  tied 0 (write only).
- lcd_en  out  1  LCD enable strobe.
- lcd_data  out  8  LCD data bus.
- busy  out  1  high in every state except IDLE.
- owner  out  1  requester currently owning or last granted the bus.

## Operation
- The FSM has six states: POWERUP, IDLE, SETUP, PULSE, HOLD, EXEC. A single down-counter is sized by $clog2 of the largest parameter and reloads on each state entry.
- **POWERUP:** counts POWERUP_CYC cycles, then moves to IDLE.
- **IDLE, grant rules:**
  - If locked, only `owner` may be granted.
  - Otherwise, if exactly one requester is valid, it is granted.
  - Otherwise, if both are valid, the round-robin pointer `rr` picks.
  - `reqN_ready` = (state==IDLE) && granted(N). It is combinational from the valids, `rr`, and the lock.
- **On accept (valid && ready):**
  - Latch rs/data onto lcd_rs/lcd_data.
  - Set `owner`.
  - Set `lock` = !last.
  - If last, set `rr` = other requester.
  - Go to SETUP.
- **SETUP:** SETUP_CYC cycles, lcd_en=0.
- **PULSE:** EN_HIGH_CYC cycles, lcd_en=1.
- **HOLD:** HOLD_CYC cycles, lcd_en=0.
- **EXEC:** waits CLEAR_EXEC_CYC cycles if the latched rs=0 and the byte is 0x01, 0x02, or 0x03. Otherwise waits EXEC_CYC cycles. Then returns to IDLE.
- lcd_rs and lcd_data change only on accept. They hold their value through EXEC and IDLE.
- A locked owner that drops valid keeps the bus; the other requester stalls indefinitely. Requesters must always complete their packets.
- Reset values:
  - lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00
  - reqN_ready=0, busy=1, owner=0
  - rr=0 (requester 0 wins the first tie), lock=0
  - state POWERUP.
- **Reset mid-operation:** the state machine goes to POWERUP on the next edge and lcd_en is 0. The in-flight byte and the lock are discarded, and the power-up wait restarts in full.

## Timing
- Accept at edge t: lcd_rs/lcd_data valid from t+1. lcd_en is high over cycles t+1+SETUP_CYC … t+SETUP_CYC+EN_HIGH_CYC.
- The next accept occurs no earlier than t+1+SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+EXEC(byte).
- Throughput is one byte per (1+SETUP+EN_HIGH+HOLD+EXEC) cycles when a requester is continuously valid.
- Zero-latency grant: ready rises in the same cycle valid is seen in IDLE.

## Test plan
Parameters for all scenarios: POWERUP=10, SETUP=2, EN_HIGH=3, HOLD=2, EXEC=5, CLEAR_EXEC=20.
1. Release reset with req0_valid held high → ready stays low and busy stays high for 10 cycles. First accept occurs at cycle 10 after release.
2. req0 writes rs=1, data 0x41, last=1, accepted at t:
   - lcd_data=0x41 and lcd_rs=1 from t+1.
   - lcd_en high exactly on t+3..t+5.
   - The next accept is at t+13.
3. req1 writes rs=0, data 0x01 accepted at t → lcd_en high t+3..t+5. The next accept is at t+28. Repeating with 0x01 but rs=1 gives the next accept at t+13.
4. Both requesters continuously valid with last=1 on every byte → grants alternate 0,1,0,1 starting with 0. lcd_data alternates the two streams.
5. req0 sends a 3-byte packet (0x86, '2', '5', last on the third byte) while req1 is continuously valid → req1_ready stays 0 until req0's third byte is accepted. The following grant goes to req1.
6. Assert reset during PULSE → lcd_en=0 and busy=1 one cycle later. The packet is discarded; after release, the 10-cycle power-up wait elapses before any ready.
